layer_serializer: RTL and testbench

//  Sits between two fully-connected layers. Captures the NN parallel neuron outputs of a layer
//  in one cycle, then replays them one word per beat as a serial stream. The stream drives the

---
 rtl/nn_pkg.sv | 18 +
 rtl/layer_serializer.sv | 127 ++++++++++++
 tb/tb_layer_serializer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the layer serializer: FSM state encoding and index sizing.
package nn_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int NN_DEFAULT = 10;

  // Index width for an NN-word frame, never narrower than one bit.
  function automatic int idx_width(input int nn);
    return (nn > 1) ? $clog2(nn) : 1;
  endfunction

  localparam int IDX_W = idx_width(NN_DEFAULT);

endpackage

// File: rtl/layer_serializer.sv
// Captures NN parallel neuron outputs in one cycle and replays them as a serial stream,
// one word per accepted beat, with sticky overrun/misalign error flags.
module layer_serializer
  import nn_pkg::*;
#(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           in_valid,
  input  logic [NN*dataWidth-1:0] in_data,
  input  logic                    out_ready,
  input  logic                    clr_err,
  output logic                    out_valid,
  output logic [dataWidth-1:0]    out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun,
  output logic                    misalign
);

  localparam int IDX_W = idx_width(NN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [dataWidth-1:0] buf_q [NN];
  logic [dataWidth-1:0] buf_d [NN];
  logic                 overrun_q, overrun_d;
  logic                 misalign_q, misalign_d;

  logic trig_s;
  logic partial_s;
  logic accept_s;
  logic at_last_s;
  logic load_s;
  logic overrun_set_s;

  assign trig_s    = &in_valid;
  assign partial_s = (|in_valid) & ~trig_s;
  assign at_last_s = (state_q == SHIFT) && (idx_q == LAST_IDX);
  assign accept_s  = (state_q == SHIFT) && out_ready;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    load_s        = 1'b0;
    overrun_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_s) begin
          load_s  = 1'b1;
          idx_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (accept_s && at_last_s) begin
          // A trigger on the closing beat chains the next frame with no bubble.
          idx_d = '0;
          if (trig_s) begin
            load_s  = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (accept_s) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            idx_d = idx_q;
          end
          overrun_set_s = trig_s;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NN; i++) begin
      if (load_s) begin
        buf_d[i] = in_data[i*dataWidth +: dataWidth];
      end else begin
        buf_d[i] = buf_q[i];
      end
    end
  end

  // Set wins over a simultaneous clear.
  assign overrun_d  = overrun_set_s | (overrun_q & ~clr_err);
  assign misalign_d = partial_s | (misalign_q & ~clr_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      overrun_q  <= 1'b0;
      misalign_q <= 1'b0;
      for (int i = 0; i < NN; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overrun_q  <= overrun_d;
      misalign_q <= misalign_d;
      for (int i = 0; i < NN; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign busy      = (state_q == SHIFT);
  assign out_valid = busy;
  assign out_last  = at_last_s;
  assign out_data  = busy ? buf_q[idx_q] : '0;
  assign overrun   = overrun_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer: capture, replay, stalls, overrun, chaining, misalign, reset.
module tb_layer_serializer;

  localparam int NN = 10;
  localparam int DW = 16;

  logic            clk;
  logic            rst;
  logic [NN-1:0]   in_valid;
  logic [NN*DW-1:0] in_data;
  logic            out_ready;
  logic            clr_err;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            busy;
  logic            overrun;
  logic            misalign;

  int total;
  int bad;

  layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .clr_err   (clr_err),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a full frame with word i = base + i; sampled at the next rising edge.
  task automatic drive_trig(input logic [DW-1:0] base);
    in_valid = '1;
    for (int i = 0; i < NN; i++) begin
      in_data[i*DW +: DW] = base + DW'(i);
    end
  endtask

  task automatic drop_inputs();
    in_valid = '0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drop_inputs();
    out_ready = 1'b1;
    clr_err   = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, out_last, busy, overrun, misalign} !== 5'b00000 || out_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b l=%b b=%b o=%b m=%b d=%h, want all 0",
               out_valid, out_last, busy, overrun, misalign, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    @(negedge clk);
    drive_trig(16'h0100);
    @(negedge clk);
    drop_inputs();
    for (int i = 0; i < NN; i++) begin
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 16'h0100 + 16'(i) ||
          out_last !== (i == NN - 1)) begin
        bad++;
        $display("FAIL basic_beat%0d: got v=%b b=%b d=%h l=%b, want v=1 b=1 d=%h l=%b",
                 i, out_valid, busy, out_data, out_last, 16'h0100 + 16'(i), (i == NN - 1));
      end
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0 || misalign !== 1'b0) begin
      bad++;
      $display("FAIL basic_after: got b=%b v=%b o=%b m=%b, want 0 0 0 0",
               busy, out_valid, overrun, misalign);
    end
  endtask

  task automatic test_stall();
    int exp_idx;
    int accepted;
    int cyc;
    exp_idx  = 0;
    accepted = 0;
    cyc      = 0;
    @(negedge clk);
    drive_trig(16'h0100);
    @(negedge clk);
    drop_inputs();
    while (accepted < NN && cyc < 40) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'h0100 + 16'(exp_idx) ||
          out_last !== (exp_idx == NN - 1)) begin
        bad++;
        $display("FAIL stall_cyc%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 cyc, out_valid, out_data, out_last, 16'h0100 + 16'(exp_idx), (exp_idx == NN - 1));
      end
      out_ready = (cyc % 2 == 0);
      if (out_ready) begin
        exp_idx++;
        accepted++;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    total++;
    if (accepted !== NN || busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_end: got accepted=%0d busy=%b, want %0d and 0", accepted, busy, NN);
    end
  endtask

  task automatic test_overrun();
    @(negedge clk);
    drive_trig(16'h0100);
    @(negedge clk);
    drop_inputs();
    for (int i = 0; i < NN; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'h0100 + 16'(i)) begin
        bad++;
        $display("FAIL overrun_beat%0d: got v=%b d=%h, want v=1 d=%h",
                 i, out_valid, out_data, 16'h0100 + 16'(i));
      end
      if (i == 4) begin
        drive_trig(16'h0200);
      end else begin
        drop_inputs();
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
        bad++;
        $display("FAIL overrun_after%0d: got v=%b b=%b o=%b, want 0 0 1", k, out_valid, busy, overrun);
      end
      @(negedge clk);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear: got o=%b, want 0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_trig(16'h0100);
    @(negedge clk);
    drop_inputs();
    for (int i = 0; i < NN; i++) begin
      if (i == NN - 1) begin
        drive_trig(16'h0300);
      end
      @(negedge clk);
    end
    drop_inputs();
    for (int i = 0; i < NN; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'h0300 + 16'(i) || out_last !== (i == NN - 1)) begin
        bad++;
        $display("FAIL b2b_beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 i, out_valid, out_data, out_last, 16'h0300 + 16'(i), (i == NN - 1));
      end
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL b2b_after: got b=%b o=%b, want 0 0", busy, overrun);
    end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    in_valid = 10'h001;
    in_data  = '1;
    @(negedge clk);
    drop_inputs();
    total++;
    if (misalign !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL misalign_set: got m=%b b=%b v=%b, want 1 0 0", misalign, busy, out_valid);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    total++;
    if (misalign !== 1'b0) begin
      bad++;
      $display("FAIL misalign_clear: got m=%b, want 0", misalign);
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    drive_trig(16'h0100);
    @(negedge clk);
    drop_inputs();
    repeat (5) @(negedge clk);
    total++;
    if (out_data !== 16'h0105) begin
      bad++;
      $display("FAIL midrst_pre: got d=%h, want 0105", out_data);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_last, busy, overrun, misalign} !== 5'b00000 || out_data !== 16'h0000) begin
      bad++;
      $display("FAIL midrst_async: got v=%b l=%b b=%b d=%h, want all 0",
               out_valid, out_last, busy, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_idle: got v=%b b=%b, want 0 0", out_valid, busy);
    end
    drive_trig(16'h0400);
    @(negedge clk);
    drop_inputs();
    for (int i = 0; i < NN; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'h0400 + 16'(i)) begin
        bad++;
        $display("FAIL midrst_beat%0d: got v=%b d=%h, want v=1 d=%h",
                 i, out_valid, out_data, 16'h0400 + 16'(i));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_frame();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_misalign();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
